// File: rtl/intersection_controller_pkg.sv
// Shared lab traffic types: controller state encoding, ring successor and
// per-state phase durations.
package intersection_controller_pkg;

    typedef enum logic [3:0] {
        NS_GO     = 4'd0,
        NS_FLASH  = 4'd1,
        NS_YELLOW = 4'd2,
        ALL_RED_A = 4'd3,
        EW_PREP   = 4'd4,
        EW_GO     = 4'd5,
        EW_FLASH  = 4'd6,
        EW_YELLOW = 4'd7,
        ALL_RED_B = 4'd8,
        NS_PREP   = 4'd9
    } ctrl_state_e;

    // Larger of two values, used to size the phase timer.
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Successor of a state in the fixed ring; the ring never skips a state.
    function automatic ctrl_state_e next_in_ring(input ctrl_state_e s);
        case (s)
            NS_GO:     return NS_FLASH;
            NS_FLASH:  return NS_YELLOW;
            NS_YELLOW: return ALL_RED_A;
            ALL_RED_A: return EW_PREP;
            EW_PREP:   return EW_GO;
            EW_GO:     return EW_FLASH;
            EW_FLASH:  return EW_YELLOW;
            EW_YELLOW: return ALL_RED_B;
            ALL_RED_B: return NS_PREP;
            default:   return NS_GO;
        endcase
    endfunction

    // Number of cycles a state lasts; for the GO states this is the minimum green.
    function automatic int unsigned state_duration(
        input ctrl_state_e s,
        input int unsigned min_green,
        input int unsigned green_flash_time,
        input int unsigned yellow_time,
        input int unsigned all_red_time,
        input int unsigned red_yellow_time
    );
        case (s)
            NS_GO, EW_GO:         return min_green;
            NS_FLASH, EW_FLASH:   return green_flash_time;
            NS_YELLOW, EW_YELLOW: return yellow_time;
            ALL_RED_A, ALL_RED_B: return all_red_time;
            default:              return red_yellow_time;
        endcase
    endfunction

endpackage

// File: rtl/intersection_controller_phase_timer.sv
// Loadable down-counter that stops at zero; times every controller phase.
module intersection_controller_phase_timer #(
    parameter int unsigned     WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Load on phase entry, otherwise count down and hold at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-approach intersection sequencer: NS and EW alternate through a fixed
// ring of phases, green rests until the opposing side has a pending request.
module intersection_controller
    import intersection_controller_pkg::*;
#(
    parameter int unsigned MIN_GREEN        = 10,
    parameter int unsigned GREEN_FLASH_TIME = 3,
    parameter int unsigned YELLOW_TIME      = 5,
    parameter int unsigned ALL_RED_TIME     = 2,
    parameter int unsigned RED_YELLOW_TIME  = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_ns_i,
    input  logic        req_ew_i,
    output logic        ns_red_o,
    output logic        ns_yellow_o,
    output logic        ns_green_o,
    output logic        ew_red_o,
    output logic        ew_yellow_o,
    output logic        ew_green_o,
    output ctrl_state_e state_o
);

    localparam int unsigned MAX_TIME = max2(max2(max2(MIN_GREEN, GREEN_FLASH_TIME),
                                                 max2(YELLOW_TIME, ALL_RED_TIME)),
                                            RED_YELLOW_TIME);
    localparam int unsigned TW = $clog2(MAX_TIME + 1);
    localparam logic [TW-1:0] GO_RELOAD = TW'(MIN_GREEN - 1);

    ctrl_state_e   state_reg;
    ctrl_state_e   state_next;
    logic          ns_pend_reg;
    logic          ns_pend_next;
    logic          ew_pend_reg;
    logic          ew_pend_next;
    logic          ns_pend_eff;
    logic          ew_pend_eff;
    logic          timer_load;
    logic [TW-1:0] timer_load_value;
    logic [TW-1:0] timer_count;
    logic          timer_zero;

    intersection_controller_phase_timer #(
        .WIDTH       (TW),
        .RESET_VALUE (GO_RELOAD)
    ) u_phase_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load       (timer_load),
        .load_value (timer_load_value),
        .count      (timer_count),
        .zero       (timer_zero)
    );

    // A request seen this cycle counts immediately, so a GO phase past its
    // minimum green releases on the same cycle the opposing detector rises.
    assign ns_pend_eff = ns_pend_reg | (req_ns_i & (state_reg != NS_GO));
    assign ew_pend_eff = ew_pend_reg | (req_ew_i & (state_reg != EW_GO));

    // State and pending-request registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= NS_GO;
            ns_pend_reg <= 1'b0;
            ew_pend_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ns_pend_reg <= ns_pend_next;
            ew_pend_reg <= ew_pend_next;
        end
    end

    // Next state, timer reload and pending-flag update; clearing on GO entry
    // takes priority over a same-cycle set.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            NS_GO:   if (timer_zero && ew_pend_eff) state_next = NS_FLASH;
            EW_GO:   if (timer_zero && ns_pend_eff) state_next = EW_FLASH;
            default: if (timer_zero) state_next = next_in_ring(state_reg);
        endcase

        timer_load       = (state_next != state_reg);
        timer_load_value = TW'(state_duration(state_next, MIN_GREEN, GREEN_FLASH_TIME,
                                              YELLOW_TIME, ALL_RED_TIME,
                                              RED_YELLOW_TIME) - 1);

        ns_pend_next = ns_pend_reg;
        if (req_ns_i && (state_reg != NS_GO)) ns_pend_next = 1'b1;
        if ((state_next == NS_GO) && (state_reg != NS_GO)) ns_pend_next = 1'b0;

        ew_pend_next = ew_pend_reg;
        if (req_ew_i && (state_reg != EW_GO)) ew_pend_next = 1'b1;
        if ((state_next == EW_GO) && (state_reg != EW_GO)) ew_pend_next = 1'b0;
    end

    // Lamp decode from state and timer; the idle approach always shows red.
    always_comb begin
        ns_red_o    = 1'b1;
        ns_yellow_o = 1'b0;
        ns_green_o  = 1'b0;
        ew_red_o    = 1'b1;
        ew_yellow_o = 1'b0;
        ew_green_o  = 1'b0;
        case (state_reg)
            NS_GO: begin
                ns_red_o   = 1'b0;
                ns_green_o = 1'b1;
            end
            NS_FLASH: begin
                ns_red_o   = 1'b0;
                ns_green_o = ~timer_count[0];
            end
            NS_YELLOW: begin
                ns_red_o    = 1'b0;
                ns_yellow_o = 1'b1;
            end
            NS_PREP: begin
                ns_yellow_o = 1'b1;
            end
            EW_GO: begin
                ew_red_o   = 1'b0;
                ew_green_o = 1'b1;
            end
            EW_FLASH: begin
                ew_red_o   = 1'b0;
                ew_green_o = ~timer_count[0];
            end
            EW_YELLOW: begin
                ew_red_o    = 1'b0;
                ew_yellow_o = 1'b1;
            end
            EW_PREP: begin
                ew_yellow_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_o = state_reg;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller at default parameters.
module tb_intersection_controller;
    import intersection_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_ns = 1'b0;
    logic        req_ew = 1'b0;
    logic        ns_red, ns_yellow, ns_green;
    logic        ew_red, ew_yellow, ew_green;
    ctrl_state_e state;
    logic [5:0]  lamps;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};

    intersection_controller dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_ns_i    (req_ns),
        .req_ew_i    (req_ew),
        .ns_red_o    (ns_red),
        .ns_yellow_o (ns_yellow),
        .ns_green_o  (ns_green),
        .ew_red_o    (ew_red),
        .ew_yellow_o (ew_yellow),
        .ew_green_o  (ew_green),
        .state_o     (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hand-written ring schedule for both detectors held high (period 46).
    function automatic ctrl_state_e ring_state(input int k);
        int p;
        p = k % 46;
        if (p <= 9)  return NS_GO;
        if (p <= 12) return NS_FLASH;
        if (p <= 17) return NS_YELLOW;
        if (p <= 19) return ALL_RED_A;
        if (p <= 22) return EW_PREP;
        if (p <= 32) return EW_GO;
        if (p <= 35) return EW_FLASH;
        if (p <= 40) return EW_YELLOW;
        if (p <= 42) return ALL_RED_B;
        return NS_PREP;
    endfunction

    // Flash lamp is lit on the first and third flash cycle.
    function automatic logic ring_flash_on(input int k);
        int p;
        p = k % 46;
        return (p == 10) || (p == 12) || (p == 33) || (p == 35);
    endfunction

    // Expected lamps {ns r,y,g, ew r,y,g} per state.
    function automatic logic [5:0] lamps_for(input ctrl_state_e s, input logic flash_on);
        case (s)
            NS_GO:     return 6'b001_100;
            NS_FLASH:  return flash_on ? 6'b001_100 : 6'b000_100;
            NS_YELLOW: return 6'b010_100;
            EW_PREP:   return 6'b100_110;
            EW_GO:     return 6'b100_001;
            EW_FLASH:  return flash_on ? 6'b100_001 : 6'b100_000;
            EW_YELLOW: return 6'b100_010;
            NS_PREP:   return 6'b110_100;
            default:   return 6'b100_100;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input logic ns, input logic ew);
        rst = 1'b1;
        req_ns = ns;
        req_ew = ew;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check_safety();
        check($sformatf("safety_green c%0d", cyc), 32'(ns_green && ew_green), 32'd0);
        check($sformatf("safety_nonred c%0d", cyc), 32'(!ns_red && !ew_red), 32'd0);
    endtask

    initial begin
        ctrl_state_e exp_s;

        // Idle detectors: rests in NS_GO with fixed lamps.
        do_reset(1'b0, 1'b0);
        check("reset_state", 32'(state), 32'(NS_GO));
        check("reset_lamps", 32'(lamps), 32'(6'b001_100));
        for (int k = 0; k < 200; k++) begin
            check($sformatf("idle_state c%0d", cyc), 32'(state), 32'(NS_GO));
            check($sformatf("idle_lamps c%0d", cyc), 32'(lamps), 32'(6'b001_100));
            step();
        end

        // One-cycle EW pulse at cycle 2.
        do_reset(1'b0, 1'b0);
        for (int k = 0; k <= 40; k++) begin
            req_ew = (k == 2);
            exp_s = (k < 23) ? ring_state(k) : EW_GO;
            check($sformatf("pulse_state c%0d", cyc), 32'(state), 32'(exp_s));
            check($sformatf("pulse_lamps c%0d", cyc), 32'(lamps),
                  32'(lamps_for(exp_s, ring_flash_on(k))));
            if (k == 23) check("pulse_ew_pend_c23", 32'(dut.ew_pend_reg), 32'd0);
            check_safety();
            step();
        end
        req_ew = 1'b0;

        // EW request after minimum green: releases on the next cycle.
        do_reset(1'b0, 1'b0);
        while (cyc < 40) step();
        req_ew = 1'b1;
        check("late_req_c40", 32'(state), 32'(NS_GO));
        step();
        check("late_req_c41", 32'(state), 32'(NS_FLASH));
        check("late_req_c41_green", 32'(ns_green), 32'd1);
        req_ew = 1'b0;

        // Both detectors held: continuous alternation.
        do_reset(1'b1, 1'b1);
        for (int k = 0; k < 200; k++) begin
            check($sformatf("both_state c%0d", cyc), 32'(state), 32'(ring_state(k)));
            check($sformatf("both_lamps c%0d", cyc), 32'(lamps),
                  32'(lamps_for(ring_state(k), ring_flash_on(k))));
            check_safety();
            step();
        end

        // Asynchronous reset between edges during EW_YELLOW.
        do_reset(1'b1, 1'b1);
        while (cyc < 37) step();
        check("mid_reset_pre", 32'(state), 32'(EW_YELLOW));
        #2 rst = 1'b1;
        #1;
        check("mid_reset_state", 32'(state), 32'(NS_GO));
        check("mid_reset_lamps", 32'(lamps), 32'(6'b001_100));
        @(negedge clk);
        check("mid_reset_hold", 32'(lamps), 32'(6'b001_100));
        rst = 1'b0;
        cyc = 0;
        for (int k = 0; k <= 10; k++) begin
            check($sformatf("post_reset_state c%0d", cyc), 32'(state), 32'(ring_state(k)));
            step();
        end

        // NS detector during its own green is ignored.
        do_reset(1'b0, 1'b0);
        for (int k = 0; k <= 60; k++) begin
            req_ns = (k >= 2) && (k <= 20);
            check($sformatf("own_req_state c%0d", cyc), 32'(state), 32'(NS_GO));
            check($sformatf("own_req_pend c%0d", cyc), 32'(dut.ns_pend_reg), 32'd0);
            step();
        end
        req_ns = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
